eth_test_rx_filter: RTL and testbench

- Sits between the Ethernet frame receiver (eth_axis_rx style header + AXI-Stream payload) and the test-pattern receive checker.
- Accepts only test-pattern frames (destination MAC and EtherType match) and forwards them unchanged to the checker. All other frames are consumed and discarded.
- Maintains saturating frame, drop, length-error and tuser-error statistics for debug readout.

---
 rtl/eth_test_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/eth_test_rx_filter.sv | 174 +++++++++++++++++
 tb/tb_eth_test_rx_filter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_test_pkg.sv
// Shared types and constants for the Ethernet test-pattern receive path.
package eth_test_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdrOut,
        StPass,
        StDrop
    } state_e;

    localparam logic [15:0] ETH_TYPE_TEST = 16'h88B5;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/eth_test_rx_filter.sv
// Forwards test-pattern frames (dest MAC + EtherType match) to the checker and
// swallows everything else, keeping saturating debug statistics.
module eth_test_rx_filter
    import eth_test_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DATA_LENGTH      = 64,
    parameter logic [15:0] ETH_TYPE         = ETH_TYPE_TEST,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter int unsigned COUNT_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [47:0]            local_mac,

    input  logic                   s_eth_hdr_valid,
    output logic                   s_eth_hdr_ready,
    input  logic [47:0]            s_eth_dest_mac,
    input  logic [47:0]            s_eth_src_mac,
    input  logic [15:0]            s_eth_type,
    input  logic [DATA_WIDTH-1:0]  s_eth_payload_axis_tdata,
    input  logic                   s_eth_payload_axis_tvalid,
    output logic                   s_eth_payload_axis_tready,
    input  logic                   s_eth_payload_axis_tlast,
    input  logic                   s_eth_payload_axis_tuser,

    output logic                   m_eth_hdr_valid,
    input  logic                   m_eth_hdr_ready,
    output logic [47:0]            m_eth_dest_mac,
    output logic [47:0]            m_eth_src_mac,
    output logic [15:0]            m_eth_type,
    output logic [DATA_WIDTH-1:0]  m_eth_payload_axis_tdata,
    output logic                   m_eth_payload_axis_tvalid,
    input  logic                   m_eth_payload_axis_tready,
    output logic                   m_eth_payload_axis_tlast,
    output logic                   m_eth_payload_axis_tuser,

    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] drop_count,
    output logic [15:0]            length_error_count,
    output logic [15:0]            tuser_error_count
);

    state_e      state_q;
    logic        hdr_valid_q;
    logic [47:0] dest_q;
    logic [47:0] src_q;
    logic [15:0] type_q;
    logic [15:0] beat_cnt_q;

    logic        dest_ok;
    logic        match;
    logic        pass_fire;
    logic        frame_inc;
    logic        drop_inc;
    logic        len_err_inc;
    logic        tuser_inc;
    logic [16:0] beat_next;

    assign dest_ok = (s_eth_dest_mac == local_mac) ||
                     (ACCEPT_BROADCAST && (s_eth_dest_mac == BROADCAST_MAC));
    assign match   = enable && (s_eth_type == ETH_TYPE) && dest_ok;

    assign pass_fire = (state_q == StPass) && s_eth_payload_axis_tvalid &&
                       m_eth_payload_axis_tready;
    assign frame_inc = pass_fire && s_eth_payload_axis_tlast;
    assign drop_inc  = (state_q == StDrop) && s_eth_payload_axis_tvalid &&
                       s_eth_payload_axis_tlast;

    // One extra bit so a saturated beat counter still reads as a length error.
    assign beat_next   = {1'b0, beat_cnt_q} + 17'd1;
    assign len_err_inc = frame_inc && (beat_next != 17'(DATA_LENGTH));
    assign tuser_inc   = frame_inc && s_eth_payload_axis_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hdr_valid_q <= 1'b0;
            dest_q      <= '0;
            src_q       <= '0;
            type_q      <= '0;
            beat_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (s_eth_hdr_valid) begin
                        dest_q <= s_eth_dest_mac;
                        src_q  <= s_eth_src_mac;
                        type_q <= s_eth_type;
                        if (match) begin
                            hdr_valid_q <= 1'b1;
                            state_q     <= StHdrOut;
                        end else begin
                            state_q <= StDrop;
                        end
                    end
                end
                StHdrOut: begin
                    if (m_eth_hdr_ready) begin
                        hdr_valid_q <= 1'b0;
                        state_q     <= StPass;
                    end
                end
                StPass: begin
                    if (pass_fire) begin
                        if (s_eth_payload_axis_tlast) begin
                            beat_cnt_q <= '0;
                            state_q    <= StIdle;
                        end else if (beat_cnt_q != 16'hFFFF) begin
                            beat_cnt_q <= beat_cnt_q + 16'd1;
                        end
                    end
                end
                StDrop: begin
                    if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        s_eth_hdr_ready           = (state_q == StIdle);
        s_eth_payload_axis_tready = 1'b0;
        m_eth_payload_axis_tvalid = 1'b0;
        if (state_q == StPass) begin
            s_eth_payload_axis_tready = m_eth_payload_axis_tready;
            m_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid;
        end else if (state_q == StDrop) begin
            s_eth_payload_axis_tready = 1'b1;
        end
    end

    assign m_eth_payload_axis_tdata = s_eth_payload_axis_tdata;
    assign m_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
    assign m_eth_payload_axis_tuser = s_eth_payload_axis_tuser;

    assign m_eth_hdr_valid = hdr_valid_q;
    assign m_eth_dest_mac  = dest_q;
    assign m_eth_src_mac   = src_q;
    assign m_eth_type      = type_q;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_inc),
        .count (frame_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .count (drop_count)
    );

    sat_counter #(.WIDTH(16)) u_len_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (len_err_inc),
        .count (length_error_count)
    );

    sat_counter #(.WIDTH(16)) u_tuser_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tuser_inc),
        .count (tuser_error_count)
    );

endmodule

// File: tb/tb_eth_test_rx_filter.sv
// Randomised frame-level bench for eth_test_rx_filter with a queue-based reference model.
module tb_eth_test_rx_filter;

    localparam int unsigned CW      = 4;
    localparam int unsigned DLEN    = 64;
    localparam int          FMAX    = 15;
    localparam int          EMAX    = 65535;
    localparam logic [47:0] LOCAL   = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] TTYPE   = 16'h88B5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic [47:0]   local_mac = LOCAL;
    logic          s_eth_hdr_valid = 1'b0;
    logic          s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac = '0;
    logic [47:0]   s_eth_src_mac = '0;
    logic [15:0]   s_eth_type = '0;
    logic [7:0]    s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic          s_tuser = 1'b0;
    logic          m_eth_hdr_valid;
    logic          m_eth_hdr_ready = 1'b1;
    logic [47:0]   m_eth_dest_mac;
    logic [47:0]   m_eth_src_mac;
    logic [15:0]   m_eth_type;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;
    logic [15:0]   length_error_count;
    logic [15:0]   tuser_error_count;

    eth_test_rx_filter #(
        .DATA_WIDTH       (8),
        .DATA_LENGTH      (DLEN),
        .ETH_TYPE         (TTYPE),
        .ACCEPT_BROADCAST (1'b1),
        .COUNT_WIDTH      (CW)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .enable                    (enable),
        .local_mac                 (local_mac),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_tdata),
        .s_eth_payload_axis_tvalid (s_tvalid),
        .s_eth_payload_axis_tready (s_tready),
        .s_eth_payload_axis_tlast  (s_tlast),
        .s_eth_payload_axis_tuser  (s_tuser),
        .m_eth_hdr_valid           (m_eth_hdr_valid),
        .m_eth_hdr_ready           (m_eth_hdr_ready),
        .m_eth_dest_mac            (m_eth_dest_mac),
        .m_eth_src_mac             (m_eth_src_mac),
        .m_eth_type                (m_eth_type),
        .m_eth_payload_axis_tdata  (m_tdata),
        .m_eth_payload_axis_tvalid (m_tvalid),
        .m_eth_payload_axis_tready (m_tready),
        .m_eth_payload_axis_tlast  (m_tlast),
        .m_eth_payload_axis_tuser  (m_tuser),
        .frame_count               (frame_count),
        .drop_count                (drop_count),
        .length_error_count        (length_error_count),
        .tuser_error_count         (tuser_error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] typ;
        int          acc;
    } hdr_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    hdr_t  exp_hdr_q[$];
    beat_t exp_beat_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_frames = 0;
    int exp_drops = 0;
    int exp_len = 0;
    int exp_tuser = 0;
    bit mon_en = 1'b0;
    bit bp_mode = 1'b0;
    int hdr_hold = 0;
    int last_hdr_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic timeout_abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
        finish_tb();
    endtask

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hdr_hold > 0 && m_eth_hdr_valid) begin
                m_eth_hdr_ready = 1'b0;
                hdr_hold--;
            end else begin
                m_eth_hdr_ready = bp_mode ? 1'($urandom % 2) : 1'b1;
            end
            m_tready = bp_mode ? 1'(($urandom % 4) != 0) : 1'b1;
        end
    end

    // Output monitor: compares counters, header and payload against the model every cycle.
    bit hdr_active = 1'b0;
    int hdr_wait = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            hdr_active = 1'b0;
            hdr_wait = 0;
        end else begin
            chk("frame_count", 64'(frame_count), 64'(exp_frames));
            chk("drop_count", 64'(drop_count), 64'(exp_drops));
            chk("length_error_count", 64'(length_error_count), 64'(exp_len));
            chk("tuser_error_count", 64'(tuser_error_count), 64'(exp_tuser));
            if (m_eth_hdr_valid) begin
                if (exp_hdr_q.size() == 0) begin
                    chk("hdr_unexpected", 64'(m_eth_hdr_valid), 64'd0);
                end else begin
                    chk("hdr_dest", 64'(m_eth_dest_mac), 64'(exp_hdr_q[0].dest));
                    chk("hdr_src", 64'(m_eth_src_mac), 64'(exp_hdr_q[0].src));
                    chk("hdr_type", 64'(m_eth_type), 64'(exp_hdr_q[0].typ));
                    if (!hdr_active) chk("hdr_latency", 64'(cyc), 64'(exp_hdr_q[0].acc));
                    hdr_active = 1'b1;
                    if (m_eth_hdr_ready) begin
                        last_hdr_wait = hdr_wait;
                        hdr_wait = 0;
                        hdr_active = 1'b0;
                        void'(exp_hdr_q.pop_front());
                    end else begin
                        hdr_wait++;
                    end
                end
            end else if (hdr_active) begin
                chk("hdr_valid_dropped", 64'(m_eth_hdr_valid), 64'd1);
                hdr_active = 1'b0;
                hdr_wait = 0;
            end
            if (m_tvalid) begin
                if (exp_beat_q.size() == 0 || exp_hdr_q.size() != 0) begin
                    chk("beat_unexpected", 64'(m_tvalid), 64'd0);
                end else if (m_tready) begin
                    chk("beat_data", 64'(m_tdata), 64'(exp_beat_q[0].data));
                    chk("beat_last", 64'(m_tlast), 64'(exp_beat_q[0].last));
                    chk("beat_user", 64'(m_tuser), 64'(exp_beat_q[0].user));
                    void'(exp_beat_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        s_eth_hdr_valid = 1'b0;
        s_tvalid = 1'b1;
        s_tlast = 1'b0;
        hdr_hold = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_hdr_q.delete();
        exp_beat_q.delete();
        exp_frames = 0;
        exp_drops = 0;
        exp_len = 0;
        exp_tuser = 0;
        @(negedge clk);
        chk("rst_hdr_ready", 64'(s_eth_hdr_ready), 64'd1);
        chk("rst_hdr_valid", 64'(m_eth_hdr_valid), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_len_err", 64'(length_error_count), 64'd0);
        chk("rst_tuser_err", 64'(tuser_error_count), 64'd0);
        chk("rst_hdr_dest", 64'(m_eth_dest_mac), 64'd0);
        chk("rst_hdr_type", 64'(m_eth_type), 64'd0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // Sends one frame; abort_at >= 0 stops after that many beats without tlast.
    task automatic send_frame(input logic [47:0] dest, input logic [15:0] typ, input bit en,
                              input int len, input bit tuser_last, input bit gaps,
                              input int abort_at);
        beat_t      beats[$];
        beat_t      b;
        bit         match;
        int         waited;
        logic [63:0] rnd;
        match = en && (typ == TTYPE) && (dest == LOCAL || dest == BCAST);
        for (int i = 0; i < len; i++) begin
            b.data = 8'($urandom);
            b.last = (i == len - 1);
            b.user = b.last ? tuser_last : 1'(($urandom % 8) == 0);
            beats.push_back(b);
        end
        rnd = {$urandom, $urandom};
        s_eth_dest_mac = dest;
        s_eth_src_mac = rnd[47:0];
        s_eth_type = typ;
        enable = en;
        s_eth_hdr_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (s_eth_hdr_ready) break;
            waited++;
            if (waited > 1000) timeout_abort("hdr_accept_timeout");
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 1'b0;
        enable = 1'($urandom % 2);
        if (match) begin
            exp_hdr_q.push_back('{dest: dest, src: rnd[47:0], typ: typ, acc: cyc});
            foreach (beats[i]) exp_beat_q.push_back(beats[i]);
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                s_tvalid = 1'b0;
                return;
            end
            if (gaps && ($urandom % 3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tdata = beats[i].data;
            s_tlast = beats[i].last;
            s_tuser = beats[i].user;
            s_tvalid = 1'b1;
            waited = 0;
            forever begin
                @(negedge clk);
                if (!match) chk("drop_tready", 64'(s_tready), 64'd1);
                if (s_tready) break;
                waited++;
                if (waited > 1000) timeout_abort("payload_timeout");
                @(posedge clk);
                #1;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (match) begin
            exp_frames = sat_inc(exp_frames, FMAX);
            if (len != DLEN) exp_len = sat_inc(exp_len, EMAX);
            if (tuser_last) exp_tuser = sat_inc(exp_tuser, EMAX);
        end else begin
            exp_drops = sat_inc(exp_drops, FMAX);
        end
        @(negedge clk);
        chk("hdr_ready_after_tlast", 64'(s_eth_hdr_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        timeout_abort("global_watchdog");
    end

    initial begin
        logic [47:0] dest;
        logic [15:0] typ;
        logic [63:0] rnd;
        int          len;
        do_reset();

        send_frame(LOCAL, TTYPE, 1'b1, 64, 1'b0, 1'b0, -1);
        chk("unicast_frame_count", 64'(frame_count), 64'd1);
        chk("unicast_len_err", 64'(length_error_count), 64'd0);
        send_frame(LOCAL, 16'h0800, 1'b1, 64, 1'b0, 1'b0, -1);
        chk("type_drop_count", 64'(drop_count), 64'd1);
        send_frame(48'h02_00_00_00_00_02, TTYPE, 1'b1, 64, 1'b0, 1'b0, -1);
        chk("mac_drop_count", 64'(drop_count), 64'd2);
        send_frame(BCAST, TTYPE, 1'b1, 64, 1'b0, 1'b0, -1);
        chk("bcast_frame_count", 64'(frame_count), 64'd2);
        send_frame(BCAST, TTYPE, 1'b0, 64, 1'b0, 1'b0, -1);
        chk("disabled_drop_count", 64'(drop_count), 64'd3);
        hdr_hold = 5;
        send_frame(LOCAL, TTYPE, 1'b1, 64, 1'b0, 1'b0, -1);
        chk("hdr_hold_wait", 64'(last_hdr_wait), 64'd5);
        bp_mode = 1'b1;
        send_frame(LOCAL, TTYPE, 1'b1, 64, 1'b0, 1'b1, -1);
        bp_mode = 1'b0;
        chk("bp_frame_count", 64'(frame_count), 64'd4);
        send_frame(LOCAL, TTYPE, 1'b1, 63, 1'b0, 1'b0, -1);
        chk("short_len_err", 64'(length_error_count), 64'd1);
        send_frame(LOCAL, TTYPE, 1'b1, 64, 1'b1, 1'b0, -1);
        chk("tuser_err", 64'(tuser_error_count), 64'd1);
        chk("tuser_len_err", 64'(length_error_count), 64'd1);

        do_reset();
        for (int i = 0; i < 17; i++) send_frame(LOCAL, 16'h0800, 1'b1, 3, 1'b0, 1'b0, -1);
        chk("drop_saturated", 64'(drop_count), 64'd15);
        chk("drop_sat_frames", 64'(frame_count), 64'd0);

        send_frame(LOCAL, TTYPE, 1'b1, 64, 1'b0, 1'b0, 10);
        do_reset();

        for (int f = 0; f < 150; f++) begin
            if (f % 12 == 0) do_reset();
            rnd = {$urandom, $urandom};
            case ($urandom % 4)
                0, 1:    dest = LOCAL;
                2:       dest = BCAST;
                default: dest = rnd[47:0];
            endcase
            typ = (($urandom % 4) != 0) ? TTYPE : 16'($urandom);
            case ($urandom % 4)
                0, 1:    len = 64;
                2:       len = $urandom_range(62, 66);
                default: len = $urandom_range(1, 20);
            endcase
            bp_mode = 1'($urandom % 2);
            if (($urandom % 3) == 0) hdr_hold = $urandom_range(1, 4);
            send_frame(dest, typ, 1'(($urandom % 5) != 0), len, 1'($urandom % 2),
                       1'($urandom % 2), -1);
        end
        bp_mode = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_hdr_q_empty", 64'(exp_hdr_q.size()), 64'd0);
        chk("final_beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
        finish_tb();
    end

endmodule
